board_uart_tx: RTL and testbench

Serialises a snapshot of the 256-bit chess board and the side-to-move bit into an 83-character ASCII diagram, sent over a UART 8N1 TX line to a host terminal. It sits beside the board builder, which writes the board, and is the read-out end of the board bus. It consumes the same `board` vector and `moveData[13]` turn bit that drive the display, and is started by a one-cycle `send` request.

---
 rtl/board_uart_tx.sv | 196 +++++++++++++++++++
 tb/tb_board_uart_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_uart_tx.sv
// board_uart_tx
// Serialises a snapshot of the 64-square chess board plus the side-to-move
// bit into an 83-character ASCII diagram (8 ranks of 8 pieces + CR LF, then
// 'W'/'B' + CR LF) and sends it over a UART 8N1 line.
//
// Ports
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   send   : one-cycle start request, only honoured while idle
//   board  : 64 x 4-bit piece codes, square n in board[4n+3:4n] (n=0 is a1)
//   turn   : side to move, 0 = white, 1 = black
//   tx     : UART line, idle high, LSB first, 1 start / 8 data / 1 stop
//   busy   : high for the whole message
//   done   : one-cycle pulse once the final stop bit has been sent
module board_uart_tx #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         send,
    input  logic [255:0] board,
    input  logic         turn,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [7:0] LAST_CLK  = 8'(CLKS_PER_BIT - 1);
    localparam logic [6:0] LAST_CHAR = 7'd82;

    state_t         state;
    logic [7:0]     clk_cnt;
    logic [2:0]     bit_idx;
    logic [6:0]     char_idx;
    logic [2:0]     rank;
    logic [3:0]     col;
    logic [1:0]     trailer;
    logic           in_trailer;
    logic [255:0]   snap_board;
    logic           snap_turn;

    logic [7:0]     cur_byte;
    logic [5:0]     square;
    logic [3:0]     nibble;
    logic [2:0]     next_bit;
    logic           bit_end;

    assign bit_end  = (clk_cnt == LAST_CLK);
    assign next_bit = bit_idx + 3'd1;
    assign square   = {rank, col[2:0]};
    assign nibble   = snap_board[{square, 2'b00} +: 4];

    // Character currently being sent, decoded straight from the snapshot.
    // Black pieces become lowercase by setting ASCII bit 5; empty and
    // reserved squares keep the same glyph whatever the colour bit says.
    always_comb begin
        cur_byte = 8'h3F;
        if (in_trailer) begin
            case (trailer)
                2'd0:    cur_byte = snap_turn ? 8'h42 : 8'h57;
                2'd1:    cur_byte = 8'h0D;
                default: cur_byte = 8'h0A;
            endcase
        end else if (col == 4'd8) begin
            cur_byte = 8'h0D;
        end else if (col == 4'd9) begin
            cur_byte = 8'h0A;
        end else begin
            case (nibble[2:0])
                3'd0:    cur_byte = 8'h2E;
                3'd1:    cur_byte = 8'h50;
                3'd2:    cur_byte = 8'h4E;
                3'd3:    cur_byte = 8'h42;
                3'd4:    cur_byte = 8'h52;
                3'd5:    cur_byte = 8'h51;
                3'd6:    cur_byte = 8'h4B;
                default: cur_byte = 8'h3F;
            endcase
            if (nibble[3] && (nibble[2:0] != 3'd0) && (nibble[2:0] != 3'd7)) begin
                cur_byte = cur_byte | 8'h20;
            end
        end
    end

    // Transmit sequencer. tx/busy/done are registered so each state's line
    // level appears on the same edge the state is entered; the next data bit
    // is therefore loaded one cycle-slot ahead from cur_byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            clk_cnt    <= 8'd0;
            bit_idx    <= 3'd0;
            char_idx   <= 7'd0;
            rank       <= 3'd0;
            col        <= 4'd0;
            trailer    <= 2'd0;
            in_trailer <= 1'b0;
            snap_board <= '0;
            snap_turn  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    clk_cnt <= 8'd0;
                    if (send) begin
                        snap_board <= board;
                        snap_turn  <= turn;
                        char_idx   <= 7'd0;
                        rank       <= 3'd7;
                        col        <= 4'd0;
                        trailer    <= 2'd0;
                        in_trailer <= 1'b0;
                        bit_idx    <= 3'd0;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= 8'd0;
                        bit_idx <= 3'd0;
                        tx      <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= 8'd0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= next_bit;
                            tx      <= cur_byte[next_bit];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 8'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= 8'd0;
                        if (char_idx == LAST_CHAR) begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            // Walk files a..h then CR, LF; after rank 1's LF
                            // switch to the turn/CR/LF trailer.
                            char_idx <= char_idx + 7'd1;
                            tx       <= 1'b0;
                            state    <= START;
                            if (in_trailer) begin
                                trailer <= trailer + 2'd1;
                            end else if (col == 4'd9) begin
                                col <= 4'd0;
                                if (rank == 3'd0) begin
                                    in_trailer <= 1'b1;
                                    trailer    <= 2'd0;
                                end else begin
                                    rank <= rank - 3'd1;
                                end
                            end else begin
                                col <= col + 4'd1;
                            end
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_uart_tx.sv
// tb_board_uart_tx
// Self-checking bench for board_uart_tx. Captures tx/busy/done every cycle
// of a message, decodes the UART frames at bit centres and compares them with
// the expected ASCII diagram (hand-written for fixed boards, produced by a
// string-building reference model for random boards).
module tb_board_uart_tx;

    localparam int C   = 10;
    localparam int MSG = 830 * C;

    typedef struct {
        string        name;
        logic [255:0] board;
        logic         turn;
        string        text;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         send;
    logic [255:0] board;
    logic         turn;
    logic         tx;
    logic         busy;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;

    logic tx_tr   [MSG + 2];
    logic busy_tr [MSG + 2];
    logic done_tr [MSG + 2];

    vec_t vecs [4];

    board_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk  (clk),
        .reset(reset),
        .send (send),
        .board(board),
        .turn (turn),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    // Single comparison point: every check funnels through here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Pulse send so that it is sampled on the next rising edge (edge k).
    task automatic applyStimulus(input logic [255:0] b, input logic t);
        board = b;
        turn  = t;
        send  = 1'b1;
        @(posedge clk);
        #1 send = 1'b0;
    endtask

    function automatic string crlf();
        return $sformatf("%c%c", 8'd13, 8'd10);
    endfunction

    // Reference model: build the diagram text from the piece-code rules.
    function automatic string model_text(input logic [255:0] b, input logic t);
        string s;
        string up;
        logic [3:0] nib;
        logic [7:0] ch;
        s  = "";
        up = "PNBRQK";
        for (int r = 7; r >= 0; r--) begin
            for (int f = 0; f < 8; f++) begin
                nib = b[(r * 8 + f) * 4 +: 4];
                if (nib[2:0] == 3'd0)      ch = 8'h2E;
                else if (nib[2:0] == 3'd7) ch = 8'h3F;
                else begin
                    ch = up[int'(nib[2:0]) - 1];
                    if (nib[3]) ch = ch + 8'd32;
                end
                s = {s, $sformatf("%c", ch)};
            end
            s = {s, crlf()};
        end
        s = {s, t ? "B" : "W", crlf()};
        return s;
    endfunction

    function automatic logic [255:0] start_board();
        logic [255:0] b;
        int back [8];
        back = '{4, 2, 3, 5, 6, 3, 2, 4};
        b = '0;
        for (int f = 0; f < 8; f++) begin
            b[(0 * 8 + f) * 4 +: 4] = 4'(back[f]);
            b[(1 * 8 + f) * 4 +: 4] = 4'h1;
            b[(6 * 8 + f) * 4 +: 4] = 4'h9;
            b[(7 * 8 + f) * 4 +: 4] = 4'(back[f] + 8);
        end
        return b;
    endfunction

    function automatic logic [255:0] random_board();
        logic [255:0] b;
        for (int q = 0; q < 8; q++) b[q * 32 +: 32] = $urandom();
        return b;
    endfunction

    // Record one message starting right after edge k. Optionally disturbs the
    // inputs (new board/turn plus a send pulse) mid-message, or re-requests
    // send in the done cycle so the next message starts back-to-back.
    task automatic captureMessage(input int disturb_at, input bit chain,
                                  input logic [255:0] next_board, input logic next_turn);
        int last;
        last = chain ? MSG : MSG + 1;
        for (int j = 0; j <= last; j++) begin
            @(negedge clk);
            tx_tr[j]   = tx;
            busy_tr[j] = busy;
            done_tr[j] = done;
            if (j == disturb_at) begin
                board = ~board;
                turn  = ~turn;
                send  = 1'b1;
            end else if (disturb_at >= 0 && j == disturb_at + 1) begin
                send = 1'b0;
            end
            if (chain && j == MSG) begin
                board = next_board;
                turn  = next_turn;
                send  = 1'b1;
            end
        end
    endtask

    // Compare a captured trace against the expected 83-character text.
    task automatic checkMessage(input string name, input string text, input bit have_after);
        int bad_busy;
        int early_done;
        int base;
        logic [9:0] got;
        logic [7:0] e;
        logic [7:0] d;
        bad_busy   = 0;
        early_done = 0;
        for (int j = 0; j < MSG; j++) begin
            if (busy_tr[j] !== 1'b1) bad_busy++;
            if (done_tr[j] !== 1'b0) early_done++;
        end
        checkOutput({name, " busy gaps"}, bad_busy, 0);
        checkOutput({name, " early done"}, early_done, 0);
        checkOutput({name, " end tx/busy/done"}, {29'd0, tx_tr[MSG], busy_tr[MSG], done_tr[MSG]}, 32'h5);
        if (have_after) checkOutput({name, " done width"}, {31'd0, done_tr[MSG + 1]}, 0);
        for (int i = 0; i < 83; i++) begin
            base = i * 10 * C;
            for (int b = 0; b < 8; b++) d[b] = tx_tr[base + (1 + b) * C + C / 2];
            got = {tx_tr[base + 9 * C + C / 2], d, tx_tr[base + C / 2]};
            e   = text[i];
            checkOutput($sformatf("%s byte %0d", name, i), {22'd0, got}, {22'd0, 1'b1, e, 1'b0});
        end
    endtask

    // Idle-line check over a number of cycles: no start bit, no busy.
    task automatic checkIdle(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int j = 0; j < cycles; j++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        checkOutput(name, bad, 0);
    endtask

    initial begin
        string dots;
        string empty_text;
        logic [255:0] b;
        logic [255:0] orig_board;
        logic orig_turn;
        string exp_text;
        bit chain;
        bit slot_lvl [10];
        logic [9:0] slot;

        dots = "........";
        slot_lvl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Vector table: fixed boards carry hand-written text, random boards
        // take their expected text from the model.
        vecs[0].name  = "initial";
        vecs[0].board = start_board();
        vecs[0].turn  = 1'b0;
        vecs[0].text  = {"rnbqkbnr", crlf(), "pppppppp", crlf(),
                         dots, crlf(), dots, crlf(), dots, crlf(), dots, crlf(),
                         "PPPPPPPP", crlf(), "RNBQKBNR", crlf(), "W", crlf()};

        b = {64{4'h8}};
        b[56 * 4 +: 4] = 4'h7;
        b[63 * 4 +: 4] = 4'hF;
        empty_text = {"?......?", crlf()};
        for (int r = 0; r < 7; r++) empty_text = {empty_text, dots, crlf()};
        empty_text = {empty_text, "B", crlf()};
        vecs[1].name  = "empty_reserved";
        vecs[1].board = b;
        vecs[1].turn  = 1'b1;
        vecs[1].text  = empty_text;

        for (int i = 2; i < 4; i++) begin
            vecs[i].name  = $sformatf("random%0d", i - 2);
            vecs[i].board = random_board();
            vecs[i].turn  = 1'($urandom_range(0, 1));
            vecs[i].text  = model_text(vecs[i].board, vecs[i].turn);
        end

        // Reset held with send high: line must stay idle throughout.
        reset = 1'b1;
        send  = 1'b1;
        board = '0;
        turn  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset tx %0d", i), {31'd0, tx}, 1);
            checkOutput($sformatf("reset busy %0d", i), {31'd0, busy}, 0);
            checkOutput($sformatf("reset done %0d", i), {31'd0, done}, 0);
        end
        reset = 1'b0;
        send  = 1'b0;
        checkIdle("post-reset idle", 20);

        // Table messages, chained so each new send lands in the done cycle.
        applyStimulus(vecs[0].board, vecs[0].turn);
        for (int i = 0; i < 4; i++) begin
            chain = (i < 3);
            captureMessage(-1, chain, vecs[(i + 1) % 4].board, vecs[(i + 1) % 4].turn);
            checkMessage(vecs[i].name, vecs[i].text, !chain);
            if (i == 0) begin
                for (int s = 0; s < 10; s++) begin
                    for (int c = 0; c < C; c++) slot[c] = tx_tr[s * C + c];
                    checkOutput($sformatf("bit slot %0d", s), {22'd0, slot}, {22'd0, {10{slot_lvl[s]}}});
                end
            end
            if (chain) begin
                @(posedge clk);
                #1 send = 1'b0;
            end
        end
        checkIdle("after table idle", 20);

        // Snapshot: inputs flipped and send pulsed during byte 5.
        orig_board = random_board();
        orig_turn  = 1'($urandom_range(0, 1));
        exp_text   = model_text(orig_board, orig_turn);
        applyStimulus(orig_board, orig_turn);
        captureMessage(5 * 10 * C + 50, 1'b0, '0, 1'b0);
        checkMessage("snapshot", exp_text, 1'b1);
        checkIdle("no second message", 50);

        // Reset during a data bit of byte 20, then a clean full message.
        applyStimulus(random_board(), 1'b0);
        for (int j = 0; j <= 20 * 10 * C + 35; j++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort tx", {31'd0, tx}, 1);
        checkOutput("abort busy", {31'd0, busy}, 0);
        checkOutput("abort done", {31'd0, done}, 0);
        reset = 1'b0;
        checkIdle("abort idle", 5);
        orig_board = random_board();
        orig_turn  = 1'($urandom_range(0, 1));
        exp_text   = model_text(orig_board, orig_turn);
        applyStimulus(orig_board, orig_turn);
        captureMessage(-1, 1'b0, '0, 1'b0);
        checkMessage("restart", exp_text, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
